pipe_hazard_ctrl: RTL and testbench

Central sequencing controller for the five-stage pipeline (IF/ID/EX/MEM/WB). It tracks the destination-register state of in-flight instructions in its own EX/MEM/WB shadow registers. From that state it generates PC/IF-ID stall, ID/EX bubble, IF-ID flush and operand-forwarding selects. It also runs the ecall drain/halt sequence and freezes the pipeline on data-memory wait.

---
 rtl/pipe_hazard_ctrl_if.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: ID operand/destination info and EX/MEM
// status in; stall, flush, bubble, freeze and forward-select controls out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
);
    // id_valid qualifies every id_* field in the same cycle (a low id_valid means
    // ID holds a bubble). dmem_wait is the data memory's not-ready: while it is
    // high nothing may advance, so every pipeline register holds its contents.
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_write_back;
    logic              id_is_load;
    logic              id_is_ecall;
    logic              ex_brn_tkn;
    logic              dmem_wait;

    logic              pc_stall;
    logic              ifid_stall;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              pipe_freeze;
    logic              pc_redirect;
    logic [FWD_W-1:0]  fwd_a;
    logic [FWD_W-1:0]  fwd_b;
    logic              halted;

    // Debug view: FSM state (0 RUN, 1 DRAIN, 2 HALT) and the shadow trackers,
    // each packed as {valid, rd, wb, load, ecall}.
    logic [1:0]        fsm_state;
    logic [REG_AW+3:0] ex_trk;
    logic [REG_AW+3:0] mem_trk;
    logic [REG_AW+3:0] wb_trk;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_write_back, id_is_load, id_is_ecall, ex_brn_tkn, dmem_wait,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
               pc_redirect, fwd_a, fwd_b, halted, fsm_state, ex_trk, mem_trk, wb_trk
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_write_back, id_is_load, id_is_ecall, ex_brn_tkn, dmem_wait,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
               pc_redirect, fwd_a, fwd_b, halted, fsm_state, ex_trk, mem_trk, wb_trk
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: load-use stall, branch flush,
// operand forwarding, data-memory freeze and the ecall drain/halt sequence.
module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int FWD_W  = 2
) (
    input logic               clock,
    input logic               reset_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wb;
        logic              load;
        logic              ecall;
    } trk_t;

    state_t state_q, state_d;
    trk_t   ex_q, mem_q, wb_q, id_trk;
    logic   ex_live, mem_live, wb_live, load_use, branch;
    logic   pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_redirect, halted;
    logic [FWD_W-1:0] fwd_a, fwd_b;

    assign id_trk = {bus.id_valid, bus.id_rd, bus.id_write_back, bus.id_is_load, bus.id_is_ecall};

    // x0 writers are never live: they can neither cause a hazard nor be forwarded.
    assign ex_live  = ex_q.valid  & ex_q.wb  & (ex_q.rd  != '0);
    assign mem_live = mem_q.valid & mem_q.wb & (mem_q.rd != '0);
    assign wb_live  = wb_q.valid  & wb_q.wb  & (wb_q.rd  != '0);

    assign load_use = bus.id_valid & ex_live & ex_q.load &
                      ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));
    assign branch   = bus.ex_brn_tkn & ex_q.valid;

    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input logic              ex_ok,
        input logic [REG_AW-1:0] ex_rd,
        input logic              mem_ok,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_ok,
        input logic [REG_AW-1:0] wb_rd
    );
        if (!use_rs)                    return FWD_W'(0);
        else if (ex_ok && rs == ex_rd)  return FWD_W'(1);
        else if (mem_ok && rs == mem_rd) return FWD_W'(2);
        else if (wb_ok && rs == wb_rd)  return FWD_W'(3);
        else                            return FWD_W'(0);
    endfunction

    always_comb begin
        state_d     = state_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        fwd_a       = '0;
        fwd_b       = '0;
        // Outputs are held quiet while reset is asserted, even if dmem_wait is high.
        if (reset_n) begin
            fwd_a = fwd_sel(bus.id_use_rs1, bus.id_rs1, ex_live & ~ex_q.load, ex_q.rd,
                            mem_live, mem_q.rd, wb_live, wb_q.rd);
            fwd_b = fwd_sel(bus.id_use_rs2, bus.id_rs2, ex_live & ~ex_q.load, ex_q.rd,
                            mem_live, mem_q.rd, wb_live, wb_q.rd);
            case (state_q)
                HALT: begin
                    halted      = 1'b1;
                    pipe_freeze = 1'b1;
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                end
                DRAIN: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    if (bus.dmem_wait) begin
                        pipe_freeze = 1'b1;
                    end else begin
                        idex_bubble = 1'b1;
                        if (wb_q.ecall) state_d = HALT;
                    end
                end
                default: begin
                    if (bus.dmem_wait) begin
                        pipe_freeze = 1'b1;
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                    end else if (branch) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        if (load_use) begin
                            pc_stall    = 1'b1;
                            ifid_stall  = 1'b1;
                            idex_bubble = 1'b1;
                        end
                        // The ecall must actually enter EX, so a stalled ecall waits.
                        if (bus.id_valid && bus.id_is_ecall && !load_use) state_d = DRAIN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!pipe_freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (bus.id_valid && !idex_bubble) ? id_trk : '0;
        end
    end

    assign bus.pc_stall    = pc_stall;
    assign bus.ifid_stall  = ifid_stall;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.pipe_freeze = pipe_freeze;
    assign bus.pc_redirect = pc_redirect;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.halted      = halted;
    assign bus.fsm_state   = state_q;
    assign bus.ex_trk      = ex_q;
    assign bus.mem_trk     = mem_q;
    assign bus.wb_trk      = wb_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver pushes hand-computed expected
// control words; a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;
    localparam int W = 22;
    localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2;

    logic clock;
    logic reset_n;

    pipe_hazard_ctrl_if #(.REG_AW(5), .FWD_W(2)) bus ();

    pipe_hazard_ctrl #(.REG_AW(5), .FWD_W(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    function automatic logic [8:0] trk(input logic v, input logic [4:0] rd,
                                       input logic wb, input logic ld, input logic ec);
        return {v, rd, wb, ld, ec};
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, pc_redirect,
    //  fwd_a, fwd_b, halted, fsm_state, ex_trk}
    function automatic logic [W-1:0] eo(input logic ps, input logic is, input logic fl,
                                        input logic bub, input logic frz, input logic rdr,
                                        input logic [1:0] fa, input logic [1:0] fb,
                                        input logic hlt, input logic [1:0] st,
                                        input logic [8:0] t);
        return {ps, is, fl, bub, frz, rdr, fa, fb, hlt, st, t};
    endfunction

    initial begin
        logic [W-1:0] e, m, got;
        string        n;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                m   = msk_q.pop_front();
                n   = name_q.pop_front();
                got = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_bubble,
                       bus.pipe_freeze, bus.pc_redirect, bus.fwd_a, bus.fwd_b,
                       bus.halted, bus.fsm_state, bus.ex_trk};
                n_tests++;
                if ((got & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b (mask %b)", n, got, e, m);
                end
            end
        end
    end

    // Driver tasks
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic wb, input logic ld, input logic ec);
        bus.id_valid      = v;
        bus.id_rs1        = rs1;
        bus.id_use_rs1    = u1;
        bus.id_rs2        = rs2;
        bus.id_use_rs2    = u2;
        bus.id_rd         = rd;
        bus.id_write_back = wb;
        bus.id_is_load    = ld;
        bus.id_is_ecall   = ec;
    endtask

    task automatic clear_id();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Inputs are already applied (just after a posedge); queue the expectation
    // for this cycle and move to just after the next posedge.
    task automatic chk(input string name, input logic [W-1:0] e, input logic check_trk);
        exp_q.push_back(e);
        msk_q.push_back(check_trk ? {W{1'b1}} : {{(W-9){1'b1}}, 9'b0});
        name_q.push_back(name);
        @(posedge clock);
        #1;
    endtask

    // Directed stimulus
    initial begin
        reset_n        = 1'b0;
        bus.ex_brn_tkn = 1'b0;
        bus.dmem_wait  = 1'b0;
        clear_id();
        @(posedge clock);
        #1;
        chk("reset_state", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);
        reset_n = 1'b1;

        // Load-use: lw x5 then add x6,x5,x2
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        chk("lw_issue", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);
        set_id(1, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);
        chk("load_use_stall", eo(1,1,0,1,0,0,0,0,0,S_RUN,trk(1,5,1,1,0)), 1'b1);
        chk("load_use_fwd_mem", eo(0,0,0,0,0,0,2'd2,0,0,S_RUN,9'd0), 1'b1);

        // Forward priority on x7 and the kill rule
        set_id(1, 5'd6, 1, 5'd5, 1, 5'd7, 1, 0, 0);
        chk("fwd_ex_and_wb", eo(0,0,0,0,0,0,2'd1,2'd3,0,S_RUN,trk(1,6,1,0,0)), 1'b1);
        set_id(1, 5'd6, 1, 5'd7, 1, 5'd7, 1, 0, 0);
        chk("fwd_mem_ex", eo(0,0,0,0,0,0,2'd2,2'd1,0,S_RUN,9'd0), 1'b0);
        chk("fwd_wb_ex", eo(0,0,0,0,0,0,2'd3,2'd1,0,S_RUN,9'd0), 1'b0);
        set_id(1, 5'd6, 0, 5'd7, 1, 5'd7, 0, 0, 0);
        chk("fwd_x7_all_stages", eo(0,0,0,0,0,0,2'd0,2'd1,0,S_RUN,trk(1,7,1,0,0)), 1'b1);
        set_id(1, 5'd7, 0, 5'd7, 1, 5'd0, 0, 0, 0);
        chk("fwd_ex_killed", eo(0,0,0,0,0,0,2'd0,2'd2,0,S_RUN,trk(1,7,0,0,0)), 1'b1);
        set_id(1, 5'd0, 0, 5'd7, 1, 5'd0, 1, 0, 0);
        chk("fwd_wb_only", eo(0,0,0,0,0,0,2'd0,2'd3,0,S_RUN,9'd0), 1'b0);
        set_id(1, 5'd0, 1, 5'd7, 1, 5'd0, 1, 0, 0);
        chk("fwd_all_killed", eo(0,0,0,0,0,0,2'd0,2'd0,0,S_RUN,trk(1,0,1,0,0)), 1'b1);
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0);
        chk("fwd_x0_two", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b0);
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
        chk("fwd_x0_all", eo(0,0,0,0,0,0,0,0,0,S_RUN,trk(1,0,1,0,0)), 1'b1);

        // Branch taken over a load-use match
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0);
        chk("lw9_issue", eo(0,0,0,0,0,0,0,0,0,S_RUN,trk(1,0,0,0,0)), 1'b1);
        set_id(1, 5'd9, 1, 5'd0, 0, 5'd10, 1, 0, 0);
        bus.ex_brn_tkn = 1'b1;
        chk("branch_over_load_use", eo(0,0,1,1,0,1,0,0,0,S_RUN,trk(1,9,1,1,0)), 1'b1);
        bus.ex_brn_tkn = 1'b0;
        clear_id();
        chk("branch_ex_bubble", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);

        // dmem_wait held 3 cycles during a load-use
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1, 0);
        chk("lw12_issue", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);
        set_id(1, 5'd0, 0, 5'd12, 1, 5'd13, 1, 0, 0);
        bus.dmem_wait = 1'b1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("freeze_%0d", i), eo(1,1,0,0,1,0,0,0,0,S_RUN,trk(1,12,1,1,0)), 1'b1);
        bus.dmem_wait = 1'b0;
        chk("stall_after_release", eo(1,1,0,1,0,0,0,0,0,S_RUN,trk(1,12,1,1,0)), 1'b1);
        chk("fwd_after_release", eo(0,0,0,0,0,0,0,2'd2,0,S_RUN,9'd0), 1'b1);

        // Ecall drain and halt
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
        chk("ecall_in_id", eo(0,0,0,0,0,0,0,0,0,S_RUN,trk(1,13,1,0,0)), 1'b1);
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 0, 0);
        chk("drain_0", eo(1,1,0,1,0,0,0,0,0,S_DRAIN,trk(1,0,0,0,1)), 1'b1);
        chk("drain_1", eo(1,1,0,1,0,0,0,0,0,S_DRAIN,9'd0), 1'b1);
        chk("drain_2", eo(1,1,0,1,0,0,0,0,0,S_DRAIN,9'd0), 1'b1);
        chk("halt_0", eo(1,1,0,0,1,0,0,0,1,S_HALT,9'd0), 1'b1);
        bus.ex_brn_tkn = 1'b1;
        chk("halt_sticky", eo(1,1,0,0,1,0,0,0,1,S_HALT,9'd0), 1'b1);
        bus.ex_brn_tkn = 1'b0;
        clear_id();
        reset_n = 1'b0;
        chk("halt_reset", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);

        // Async reset mid-DRAIN with dmem_wait high
        reset_n = 1'b1;
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
        chk("ecall_again", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);
        clear_id();
        bus.dmem_wait = 1'b1;
        chk("drain_frozen", eo(1,1,0,0,1,0,0,0,0,S_DRAIN,trk(1,0,0,0,1)), 1'b1);
        reset_n = 1'b0;
        chk("async_reset_drain", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);
        reset_n = 1'b1;
        bus.dmem_wait = 1'b0;
        chk("after_reset", eo(0,0,0,0,0,0,0,0,0,S_RUN,9'd0), 1'b1);

        repeat (2) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
